// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter and pending-write scoreboard for the RV32I register file.
// Shares the single register-file write port between NREQ writeback
// requesters with round-robin arbitration, registers the winning write for
// one cycle, and keeps a 32-bit mask of registers with an outstanding write.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [5*NREQ-1:0]      req_rd,
    input  logic [XLEN*NREQ-1:0]   req_data,
    output logic                   wr_en,
    output logic [4:0]             wr_addr,
    output logic [XLEN-1:0]        wr_data,
    input  logic                   alloc_en,
    input  logic [4:0]             alloc_rd,
    output logic [31:0]            pending
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] ptr_nxt;
    logic             grant_any;
    logic             accept;
    logic [4:0]       sel_rd;
    logic [XLEN-1:0]  sel_data;
    logic [31:0]      pending_nxt;

    // Round-robin search starting at ptr; the first valid requester wins.
    // NOTE: every signal driven here gets a default at the top of the block so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && req_valid[(int'(ptr) + k) % NREQ]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // Ready, write-payload mux and pointer advance for the winning requester.
    always_comb begin
        req_ready = '0;
        sel_rd    = '0;
        sel_data  = '0;
        accept    = grant_any && !rst;
        ptr_nxt   = PTR_W'((int'(grant_idx) + 1) % NREQ);
        for (int i = 0; i < NREQ; i++) begin
            if (int'(grant_idx) == i) begin
                req_ready[i] = accept;
                sel_rd       = req_rd[5*i +: 5];
                sel_data     = req_data[XLEN*i +: XLEN];
            end
        end
    end

    // Scoreboard update: the registered write clears, allocation sets, and a
    // set to the same register wins because the new instruction owns it.
    always_comb begin
        pending_nxt = pending;
        if (wr_en) begin
            pending_nxt[wr_addr] = 1'b0;
        end
        if (alloc_en && alloc_rd != 5'd0) begin
            pending_nxt[alloc_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // State: pointer, output write register and pending mask.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            pending <= '0;
        end else begin
            pending <= pending_nxt;
            wr_en   <= accept && (sel_rd != 5'd0);
            if (accept) begin
                ptr <= ptr_nxt;
            end
            // A write to x0 is consumed without touching the output payload.
            if (accept && sel_rd != 5'd0) begin
                wr_addr <= sel_rd;
                wr_data <= sel_data;
            end
        end
    end

    // A requester holds valid, rd and data steady until it is accepted.
    for (genvar g = 0; g < NREQ; g++) begin : g_hold_chk
        a_valid_held : assert property (@(posedge clk) disable iff (rst)
            (req_valid[g] && !req_ready[g]) |=> req_valid[g]);
        a_payload_held : assert property (@(posedge clk) disable iff (rst)
            (req_valid[g] && !req_ready[g]) |=>
                ($stable(req_rd[5*g +: 5]) && $stable(req_data[XLEN*g +: XLEN])));
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, round-robin
// rotation, x0 drop, scoreboard set/clear, set-wins collision, mid-stream reset.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [5*NREQ-1:0]    req_rd;
    logic [XLEN*NREQ-1:0] req_data;
    logic                 wr_en;
    logic [4:0]           wr_addr;
    logic [XLEN-1:0]      wr_data;
    logic                 alloc_en;
    logic [4:0]           alloc_rd;
    logic [31:0]          pending;

    logic [4:0]      rd  [NREQ];
    logic [XLEN-1:0] dat [NREQ];
    int              rem [NREQ];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Pack the per-requester stimulus onto the flat buses.
    always_comb begin
        req_rd   = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_rd[5*i +: 5]          = rd[i];
            req_data[XLEN*i +: XLEN]  = dat[i];
        end
    end

    regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .alloc_en  (alloc_en),
        .alloc_rd  (alloc_rd),
        .pending   (pending)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        alloc_en  = 1'b0;
        alloc_rd  = '0;
        for (int i = 0; i < NREQ; i++) begin
            rd[i]  = '0;
            dat[i] = '0;
            rem[i] = 0;
        end

        // Reset: ready gated off even with every requester valid.
        req_valid = 3'b111;
        @(negedge clk);
        check("rst_ready", req_ready, 3'b000);
        tick();
        req_valid = '0;
        tick();
        rst = 1'b0;
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_addr", wr_addr, 5'd0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_pending", pending, 32'h0);

        // Single ALU write.
        rd[0] = 5'd5; dat[0] = 32'hDEADBEEF; req_valid = 3'b001;
        @(negedge clk);
        check("single_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        check("single_wr_en", wr_en, 1'b1);
        check("single_wr_addr", wr_addr, 5'd5);
        check("single_wr_data", wr_data, 32'hDEADBEEF);
        tick();
        check("single_wr_en_drop", wr_en, 1'b0);

        // Round-robin: each requester presents two writes, grants rotate 0,1,2.
        do_reset();
        rd[0] = 5'd1; dat[0] = 32'h11111111;
        rd[1] = 5'd2; dat[1] = 32'h22222222;
        rd[2] = 5'd3; dat[2] = 32'h33333333;
        for (int i = 0; i < NREQ; i++) rem[i] = 2;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NREQ; i++) req_valid[i] = (rem[i] > 0);
            @(negedge clk);
            check("rr_grant", req_ready, 3'b001 << (c % 3));
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) rem[i]--;
            tick();
            check("rr_wr_en", wr_en, 1'b1);
            check("rr_wr_addr", wr_addr, 5'(c % 3 + 1));
            check("rr_wr_data", wr_data, dat[c % 3]);
        end
        req_valid = '0;
        tick();
        check("rr_idle", wr_en, 1'b0);

        // x0 drop: LSU accepted, nothing written, payload held, ptr -> 2.
        rd[1] = 5'd0; dat[1] = 32'h12345678; req_valid = 3'b010;
        @(negedge clk);
        check("x0_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        check("x0_wr_en", wr_en, 1'b0);
        check("x0_wr_addr_hold", wr_addr, 5'd3);
        check("x0_wr_data_hold", wr_data, 32'h33333333);
        rd[0] = 5'd10; dat[0] = 32'hAAAA0000;
        rd[2] = 5'd11; dat[2] = 32'hBBBB0000;
        req_valid = 3'b101;
        @(negedge clk);
        check("x0_ptr_grant", req_ready, 3'b100);
        tick();
        req_valid = 3'b001;
        check("x0_next_addr", wr_addr, 5'd11);
        @(negedge clk);
        check("x0_wrap_grant", req_ready, 3'b001);
        tick();
        req_valid = '0;
        check("x0_wrap_addr", wr_addr, 5'd10);

        // Scoreboard: alloc x7 in cycle 0, CSR writeback x7 accepted cycle 3.
        alloc_en = 1'b1; alloc_rd = 5'd7;
        tick();
        alloc_en = 1'b0;
        check("sb_c1", pending, 32'h00000080);
        tick();
        check("sb_c2", pending[7], 1'b1);
        tick();
        check("sb_c3", pending[7], 1'b1);
        rd[2] = 5'd7; dat[2] = 32'hC5C5C5C5; req_valid = 3'b100;
        @(negedge clk);
        check("sb_csr_ready", req_ready, 3'b100);
        tick();
        req_valid = '0;
        check("sb_c4", pending[7], 1'b1);
        check("sb_c4_wr_en", wr_en, 1'b1);
        check("sb_c4_wr_addr", wr_addr, 5'd7);
        tick();
        check("sb_c5", pending, 32'h0);
        alloc_en = 1'b1; alloc_rd = 5'd0;
        tick();
        alloc_en = 1'b0;
        check("sb_alloc_x0", pending, 32'h0);

        // Set and clear of x9 in the same cycle: set wins.
        alloc_en = 1'b1; alloc_rd = 5'd9;
        rd[0] = 5'd9; dat[0] = 32'h99999999; req_valid = 3'b001;
        @(negedge clk);
        check("sc_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        check("sc_wr", {wr_en, wr_addr}, {1'b1, 5'd9});
        check("sc_pending_before", pending, 32'h00000200);
        tick();
        alloc_en = 1'b0;
        check("sc_set_wins", pending, 32'h00000200);
        tick();
        check("sc_still_set", pending, 32'h00000200);

        // Retire x9 while allocating x4 then x7 -> pending = 0x90, ptr -> 2.
        rd[1] = 5'd9; dat[1] = 32'h09090909; req_valid = 3'b010;
        alloc_en = 1'b1; alloc_rd = 5'd4;
        @(negedge clk);
        check("mr_pre_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        alloc_rd = 5'd7;
        tick();
        alloc_en = 1'b0;
        check("mr_pending", pending, 32'h00000090);

        // Reset in the cycle an rd=4 write is presented.
        rd[1] = 5'd4; dat[1] = 32'h44444444; req_valid = 3'b010;
        rst = 1'b1;
        @(negedge clk);
        check("mr_ready_gated", req_ready, 3'b000);
        tick();
        req_valid = '0;
        rst = 1'b0;
        check("mr_wr_en", wr_en, 1'b0);
        check("mr_pending_clr", pending, 32'h0);
        check("mr_wr_addr", wr_addr, 5'd0);
        rd[1] = 5'd6; dat[1] = 32'h66666666;
        rd[2] = 5'd8; dat[2] = 32'h88888888;
        req_valid = 3'b110;
        @(negedge clk);
        check("mr_ptr_zero", req_ready, 3'b010);
        tick();
        req_valid = 3'b100;
        check("mr_first_addr", wr_addr, 5'd6);
        @(negedge clk);
        check("mr_second_grant", req_ready, 3'b100);
        tick();
        req_valid = '0;
        check("mr_second_addr", wr_addr, 5'd8);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
